hazard_ctrl: RTL and testbench

- Hazard detection and pipeline control for the 5-stage MIPS32 pipeline.
- It is the counterpart to the forwarding path: it decides when forwarding cannot resolve a dependency, then stalls or flushes the pipeline.
- Covers three cases:
  - load-use stalls;
  - ID-stage branch operand stalls;
  - EX-stage taken-branch/jump flushes.
- Tracks a multi-cycle multiply/divide unit with a busy countdown and interlocks HI/LO readers.

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/hazard_ctrl_if.sv | 54 +++++
 rtl/muldiv_busy_cnt.sv | 68 ++++++
 rtl/hazard_ctrl.sv | 113 +++++++++++
 tb/tb_hazard_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard control block: FSM state encoding,
// the hard-wired zero register and the default mul/div latency.
package hazard_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         MULDIV_LAT_DEF = 32;
  localparam int         CNT_W_DEF      = 6;

  // A destination register collides with the ID instruction when it is not
  // $zero and matches a source operand that the instruction actually reads.
  function automatic logic reg_hit(input logic [4:0] dst,
                                   input logic [4:0] rs,
                                   input logic [4:0] rt,
                                   input logic       uses_rs,
                                   input logic       uses_rt);
    return (dst != REG_ZERO) &&
           ((uses_rs && (dst == rs)) || (uses_rt && (dst == rt)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for hazard_ctrl: ID/EX/MEM hazard sources in,
// stall/flush controls and mul/div busy out.
// Optional macro HAZARD_STATS_EN adds the stall/flush cycle counters.
interface hazard_ctrl_if;

  logic [4:0]  ID_RsAddr;
  logic [4:0]  ID_RtAddr;
  logic        ID_UsesRs;
  logic        ID_UsesRt;
  logic        ID_Branch;
  logic        ID_MulDiv;
  logic        ID_ReadHiLo;
  logic        ID_EX_RegWr;
  logic [4:0]  ID_EX_RegWrAddr;
  logic        ID_EX_MemRd;
  logic        EX_MEM_MemRd;
  logic [4:0]  EX_MEM_RegWrAddr;
  logic        EX_MulDivStart;
  logic        EX_BranchTaken;
  logic        PC_Stall;
  logic        IF_ID_Stall;
  logic        IF_ID_Flush;
  logic        ID_EX_Flush;
  logic        MulDiv_Busy;
`ifdef HAZARD_STATS_EN
  logic [31:0] Stat_StallCycles;
  logic [31:0] Stat_FlushCycles;
`endif

  // Pipeline side: drives hazard sources, consumes controls.
  modport master (
    output ID_RsAddr, ID_RtAddr, ID_UsesRs, ID_UsesRt, ID_Branch,
           ID_MulDiv, ID_ReadHiLo, ID_EX_RegWr, ID_EX_RegWrAddr,
           ID_EX_MemRd, EX_MEM_MemRd, EX_MEM_RegWrAddr,
           EX_MulDivStart, EX_BranchTaken,
`ifdef HAZARD_STATS_EN
    input  Stat_StallCycles, Stat_FlushCycles,
`endif
    input  PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Flush, MulDiv_Busy
  );

  // Hazard controller side.
  modport slave (
    input  ID_RsAddr, ID_RtAddr, ID_UsesRs, ID_UsesRt, ID_Branch,
           ID_MulDiv, ID_ReadHiLo, ID_EX_RegWr, ID_EX_RegWrAddr,
           ID_EX_MemRd, EX_MEM_MemRd, EX_MEM_RegWrAddr,
           EX_MulDivStart, EX_BranchTaken,
`ifdef HAZARD_STATS_EN
    output Stat_StallCycles, Stat_FlushCycles,
`endif
    output PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Flush, MulDiv_Busy
  );

endinterface

// File: rtl/muldiv_busy_cnt.sv
// Busy tracker for the multi-cycle mul/div unit. A start loads the
// countdown with MULDIV_LAT-1; busy drops on the edge that sees count 0,
// so a HI/LO reader is released MULDIV_LAT cycles after the start cycle.
// A start while already busy reloads the counter; flushes never cancel it.
module muldiv_busy_cnt
  import hazard_pkg::*;
#(
  parameter int MULDIV_LAT = MULDIV_LAT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MULDIV_LAT - 1);

  state_t           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             busy_d, busy_q;

  // Next-state and countdown logic for the IDLE/BUSY machine.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_BUSY;
          cnt_d   = LOAD_VAL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (start) begin
          cnt_d = LOAD_VAL;
        end else if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == ST_BUSY);
  end

  // State, counter and registered busy flag; reset aborts a busy period at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard detection for the 5-stage MIPS32 pipeline: load-use and ID-branch
// operand stalls, EX taken-branch flushes and the mul/div HI/LO interlock.
// Controls are combinational so they act in the cycle the hazard is seen.
// Optional macro HAZARD_STATS_EN adds saturating stall/flush cycle counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULDIV_LAT = MULDIV_LAT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hif
);

  logic muldiv_busy_s;
  logic ex_hit_s, mem_hit_s;
  logic load_use_s, br_ex_s, br_mem_s, md_hz_s, stall_s;
  logic pc_stall_s, if_id_stall_s, if_id_flush_s, id_ex_flush_s;

  muldiv_busy_cnt #(
    .MULDIV_LAT (MULDIV_LAT),
    .CNT_W      (CNT_W)
  ) u_busy_cnt (
    .clk   (clk),
    .reset (reset),
    .start (hif.EX_MulDivStart),
    .busy  (muldiv_busy_s)
  );

  // Hazard classification and stall/flush priority (flush wins: the stalled
  // instruction is on the wrong path anyway).
  always_comb begin
    ex_hit_s   = reg_hit(hif.ID_EX_RegWrAddr, hif.ID_RsAddr, hif.ID_RtAddr,
                         hif.ID_UsesRs, hif.ID_UsesRt);
    mem_hit_s  = reg_hit(hif.EX_MEM_RegWrAddr, hif.ID_RsAddr, hif.ID_RtAddr,
                         hif.ID_UsesRs, hif.ID_UsesRt);
    load_use_s = hif.ID_EX_MemRd && hif.ID_EX_RegWr && ex_hit_s;
    br_ex_s    = hif.ID_Branch && hif.ID_EX_RegWr && ex_hit_s;
    br_mem_s   = hif.ID_Branch && hif.EX_MEM_MemRd && mem_hit_s;
    md_hz_s    = muldiv_busy_s && (hif.ID_MulDiv || hif.ID_ReadHiLo);
    stall_s    = load_use_s || br_ex_s || br_mem_s || md_hz_s;

    if (reset) begin
      pc_stall_s    = 1'b0;
      if_id_stall_s = 1'b0;
      if_id_flush_s = 1'b0;
      id_ex_flush_s = 1'b0;
    end else if (hif.EX_BranchTaken) begin
      pc_stall_s    = 1'b0;
      if_id_stall_s = 1'b0;
      if_id_flush_s = 1'b1;
      id_ex_flush_s = 1'b1;
    end else if (stall_s) begin
      pc_stall_s    = 1'b1;
      if_id_stall_s = 1'b1;
      if_id_flush_s = 1'b0;
      id_ex_flush_s = 1'b1;
    end else begin
      pc_stall_s    = 1'b0;
      if_id_stall_s = 1'b0;
      if_id_flush_s = 1'b0;
      id_ex_flush_s = 1'b0;
    end
  end

  assign hif.PC_Stall    = pc_stall_s;
  assign hif.IF_ID_Stall = if_id_stall_s;
  assign hif.IF_ID_Flush = if_id_flush_s;
  assign hif.ID_EX_Flush = id_ex_flush_s;
  assign hif.MulDiv_Busy = muldiv_busy_s;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic [31:0] flush_cnt_d, flush_cnt_q;

  // Saturating counts of stall-only cycles and flush cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hif.EX_BranchTaken) begin
      if (flush_cnt_q != 32'hFFFF_FFFF) begin
        flush_cnt_d = flush_cnt_q + 32'd1;
      end else begin
        flush_cnt_d = flush_cnt_q;
      end
    end else if (stall_s) begin
      if (stall_cnt_q != 32'hFFFF_FFFF) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Statistics registers, cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hif.Stat_StallCycles = stall_cnt_q;
  assign hif.Stat_FlushCycles = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (MULDIV_LAT=4): directed vector table,
// multi-cycle sequences and randomized traffic against a reference model.
module tb_hazard_ctrl;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  hazard_ctrl_if hif();

  hazard_ctrl #(.MULDIV_LAT(LAT), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .hif   (hif)
  );

  // One stimulus record; exp = {PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Flush}.
  typedef struct {
    logic [4:0] rs, rt;
    logic       urs, urt, br, md, hilo, exwr;
    logic [4:0] exaddr;
    logic       exmr, memmr;
    logic [4:0] memaddr;
    logic       start, taken;
    logic [3:0] exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int rem    = 0;   // model: busy cycles still ahead

  task automatic drive(input vec_t v);
    hif.ID_RsAddr        = v.rs;
    hif.ID_RtAddr        = v.rt;
    hif.ID_UsesRs        = v.urs;
    hif.ID_UsesRt        = v.urt;
    hif.ID_Branch        = v.br;
    hif.ID_MulDiv        = v.md;
    hif.ID_ReadHiLo      = v.hilo;
    hif.ID_EX_RegWr      = v.exwr;
    hif.ID_EX_RegWrAddr  = v.exaddr;
    hif.ID_EX_MemRd      = v.exmr;
    hif.EX_MEM_MemRd     = v.memmr;
    hif.EX_MEM_RegWrAddr = v.memaddr;
    hif.EX_MulDivStart   = v.start;
    hif.EX_BranchTaken   = v.taken;
  endtask

  task automatic check(input string tag, input logic [3:0] exp_ctl, input logic exp_busy);
    logic [3:0] act;
    act = {hif.PC_Stall, hif.IF_ID_Stall, hif.IF_ID_Flush, hif.ID_EX_Flush};
    checks++;
    if (act !== exp_ctl) begin
      errors++;
      $display("FAIL %s ctl(pcst,ifst,iffl,exfl): got %b want %b", tag, act, exp_ctl);
    end
    checks++;
    if (hif.MulDiv_Busy !== exp_busy) begin
      errors++;
      $display("FAIL %s busy: got %b want %b", tag, hif.MulDiv_Busy, exp_busy);
    end
  endtask

  // Reference: register collision test straight from the hazard definition.
  function automatic logic m_hit(input logic [4:0] dst, input vec_t v);
    return (dst != 5'd0) && ((v.urs && dst == v.rs) || (v.urt && dst == v.rt));
  endfunction

  // Reference: expected controls from the hazard rules and the busy model.
  function automatic logic [3:0] model_ctl(input vec_t v, input int busy_rem);
    logic stall;
    stall = (v.exmr && v.exwr && m_hit(v.exaddr, v)) ||
            (v.br && v.exwr && m_hit(v.exaddr, v)) ||
            (v.br && v.memmr && m_hit(v.memaddr, v)) ||
            ((busy_rem > 0) && (v.md || v.hilo));
    if (v.taken) return 4'b0011;
    else if (stall) return 4'b1101;
    else return 4'b0000;
  endfunction

  // Apply one cycle of inputs (called at posedge+1), check mid-cycle,
  // then advance the busy model across the clock edge.
  task automatic cycle(input vec_t v, input string tag, input logic [3:0] exp_ctl,
                       input logic exp_busy);
    drive(v);
    #4;
    check(tag, exp_ctl, exp_busy);
    @(posedge clk);
    #1;
    if (v.start) rem = LAT;
    else if (rem > 0) rem--;
  endtask

  vec_t tbl[15];
  vec_t v;

  initial begin
    // Order: rs, rt, urs, urt, br, md, hilo, exwr, exaddr, exmr, memmr, memaddr, start, taken, exp
    tbl[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0000};
    tbl[1]  = '{5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 4'b1101};
    tbl[2]  = '{5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0000};
    tbl[3]  = '{5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0000};
    tbl[4]  = '{5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 4'b1101};
    tbl[5]  = '{5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0000};
    tbl[6]  = '{5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b1101};
    tbl[7]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 4'b1101};
    tbl[8]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 4'b0000};
    tbl[9]  = '{5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 4'b0011};
    tbl[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 4'b0011};
    tbl[11] = '{5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0000};
    tbl[12] = '{5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 4'b0000};
    tbl[13] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0000};
    tbl[14] = '{5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0000};

    // Reset with a live load-use hazard on the inputs: everything must stay 0.
    reset = 1'b1;
    drive(tbl[1]);
    #2;
    check("reset_state", 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed combinational table (unit idle throughout).
    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i], $sformatf("tbl%0d", i), tbl[i].exp, 1'b0);
    end

    // Load-use: one stall cycle, then the bubble lets add proceed.
    v = '{default: '0};
    v.rs = 5'd8; v.urs = 1'b1; v.exwr = 1'b1; v.exaddr = 5'd8; v.exmr = 1'b1;
    cycle(v, "lu_stall", 4'b1101, 1'b0);
    v.exwr = 1'b0; v.exaddr = 5'd0; v.exmr = 1'b0;
    cycle(v, "lu_release", 4'b0000, 1'b0);

    // Branch on rt=5: lw $5 in EX, then in MEM, then gone.
    v = '{default: '0};
    v.rt = 5'd5; v.urt = 1'b1; v.br = 1'b1;
    v.exwr = 1'b1; v.exmr = 1'b1; v.exaddr = 5'd5;
    cycle(v, "br_ex", 4'b1101, 1'b0);
    v.exwr = 1'b0; v.exmr = 1'b0; v.exaddr = 5'd0; v.memmr = 1'b1; v.memaddr = 5'd5;
    cycle(v, "br_mem", 4'b1101, 1'b0);
    v.memmr = 1'b0; v.memaddr = 5'd0;
    cycle(v, "br_go", 4'b0000, 1'b0);

    // Mul/div: busy 4 cycles, mflo stalled 4 cycles, released on the 5th.
    v = '{default: '0};
    v.start = 1'b1;
    cycle(v, "md_start", 4'b0000, 1'b0);
    v.start = 1'b0; v.hilo = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      cycle(v, $sformatf("md_wait%0d", i), 4'b1101, 1'b1);
    end
    cycle(v, "md_release", 4'b0000, 1'b0);

    // Reset two cycles into a busy period must clear busy with no clock edge.
    v = '{default: '0};
    v.start = 1'b1;
    cycle(v, "rst_md_start", 4'b0000, 1'b0);
    v.start = 1'b0; v.hilo = 1'b1;
    cycle(v, "rst_md_b0", 4'b1101, 1'b1);
    cycle(v, "rst_md_b1", 4'b1101, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    check("rst_async", 4'b0000, 1'b0);
    rem = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(v, "rst_after", 4'b0000, 1'b0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      vec_t r;
      logic [3:0] e;
      logic eb;
      r = '{default: '0};
      r.rs      = 5'($urandom_range(0, 3));
      r.rt      = 5'($urandom_range(0, 3));
      r.urs     = 1'($urandom_range(0, 1));
      r.urt     = 1'($urandom_range(0, 1));
      r.br      = 1'($urandom_range(0, 1));
      r.md      = ($urandom_range(0, 3) == 0);
      r.hilo    = ($urandom_range(0, 3) == 0);
      r.exwr    = 1'($urandom_range(0, 1));
      r.exaddr  = 5'($urandom_range(0, 3));
      r.exmr    = 1'($urandom_range(0, 1));
      r.memmr   = 1'($urandom_range(0, 1));
      r.memaddr = 5'($urandom_range(0, 3));
      r.start   = ($urandom_range(0, 15) == 0);
      r.taken   = ($urandom_range(0, 7) == 0);
      e  = model_ctl(r, rem);
      eb = (rem > 0);
      cycle(r, $sformatf("rand%0d", n), e, eb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
